oled_pixel_streamer: RTL
========================

Name: oled_pixel_streamer

Overview:
Scan-out engine for the 96x64 OLED. It generates the pixel coordinate X/Y and drives it into the combinational pixel renderers. It samples the returned 16-bit RGB565 oled_data and serialises each pixel MSB-first onto the panel SPI data lines. It sits between the top-level renderer mux and the OLED pins.

Parameters:
WIDTH, 96, pixels per row; X wraps at WIDTH-1.
HEIGHT, 64, rows per frame; Y wraps at HEIGHT-1.
CLK_DIV, 4, clk cycles per SCLK half-period; legal range is 1 or more.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  level; streaming runs while high
oled_data  in  16  RGB565 pixel for the current X/Y, from the renderer (combinational)
X  out  7  current column, 0..WIDTH-1
Y  out  6  current row, 0..HEIGHT-1
cs_n  out  1  SPI chip select, active low
sclk  out  1  SPI clock, idles high
sdin  out  1  SPI data, MSB first
dc  out  1  data/command select; 1 = pixel data
frame_begin  out  1  one-cycle pulse when pixel (0,0) is loaded
busy  out  1  high in LOAD and SHIFT

Behaviour:
- Reset (async, immediate, also mid-transfer) forces these values:
  - X=0, Y=0, cs_n=1, sclk=1, sdin=0, dc=0, frame_begin=0, busy=0.
  - State goes to IDLE; shift register and counters are cleared.
- State machine has three states: IDLE, LOAD, SHIFT.
- IDLE:
  - cs_n=1, sclk=1.
  - If enable=1, go to LOAD next cycle.
- LOAD (exactly 1 cycle):
  - Register oled_data into the 16-bit shift register.
  - Set cs_n=0 and dc=1.
  - Set bit counter to 15.
  - frame_begin=1 in this cycle if X==0 and Y==0.
  - Go to SHIFT.
- SHIFT, per bit:
  - Low phase: sclk=0 for CLK_DIV cycles. sdin updates to shift_reg[15] at the start of the low phase.
  - High phase: sclk=1 for CLK_DIV cycles. The panel samples on the rising edge.
  - After the high phase, shift the register left by 1 and decrement the bit counter.
- End of pixel (after bit 0's high phase):
  - Advance the coordinate:
    - If X==WIDTH-1, X=0 and Y increments.
    - Else X increments.
    - If X==WIDTH-1 and Y==HEIGHT-1, both wrap to 0.
  - Then go to LOAD if enable=1, else go to IDLE (cs_n=1).
- Timing:
  - Per-pixel latency is 1 + 32*CLK_DIV clk cycles; the default is 129.
  - A full frame with default parameters is 6144*129 cycles, with no gaps between pixels while enable stays high.
- X and Y are stable for the whole of SHIFT; they change only at pixel end. The renderer therefore has a full pixel time to settle.
- oled_data is sampled only in LOAD; changes at any other time are ignored.
- If enable is deasserted mid-pixel, the current pixel completes. Position is kept, and resuming continues from the next pixel.
- dc stays 1 once set until reset; this block never issues command bytes.
- Counters:
  - The CLK_DIV phase counter is $clog2(CLK_DIV)+1 bits wide.
  - The bit counter is 4 bits.
  - All comparisons are done at full port width.

Decomposition:
- Shared package oled_pkg holds:
  - OLED_WIDTH=96 and OLED_HEIGHT=64.
  - RGB565 pixel typedef (16 bits).
  - State enum {IDLE, LOAD, SHIFT}.
- One sub-module, spi_shift16, holds the 16-bit loadable shift register, the CLK_DIV phase counter and the bit counter.
  - Inputs: load, data, start.
  - Outputs: sclk, sdin, done pulse.
- Top level oled_pixel_streamer holds the FSM and the X/Y scan counters.

Test Plan:
1. Reset mid-SHIFT (enable=1, bit 7): within the same cycle, the outputs equal the reset values (cs_n=1, sclk=1, X=0, Y=0, busy=0).
2. CLK_DIV=1, oled_data=16'hA5C3 at (0,0), enable=1:
   - frame_begin pulses once in LOAD.
   - sdin sampled at 16 sclk rising edges reads 1010_0101_1100_0011.
   - X becomes 1 after 33 cycles.
3. Row wrap: preload to X=95, Y=0 -> after the pixel, X=0 and Y=1; no frame_begin.
4. Frame wrap: X=95, Y=63 -> X=0, Y=0 next, and frame_begin pulses in the following LOAD. Over a full run, exactly one pulse per 6144 pixels.
5. Deassert enable at bit 10 of pixel (5,2):
   - All 16 bits complete, then cs_n=1 and busy=0.
   - X=6, Y=2 is held.
   - Re-enable: next LOAD samples the pixel at (6,2).
6. Change oled_data every cycle during SHIFT: the transmitted word equals the value present in the LOAD cycle only.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED scan-out path.
package oled_pkg;

   localparam int unsigned OLED_WIDTH  = 96;
   localparam int unsigned OLED_HEIGHT = 64;
   localparam int unsigned X_W         = 7;
   localparam int unsigned Y_W         = 6;
   localparam int unsigned PIX_W       = 16;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

endpackage

// File: rtl/oled_pixel_streamer_if.sv
// Renderer/panel-side signal bundle of the pixel streamer.
interface oled_pixel_streamer_if;
   import oled_pkg::*;

   logic           enable;
   rgb565_t        oled_data;
   logic [X_W-1:0] X;
   logic [Y_W-1:0] Y;
   logic           cs_n;
   logic           sclk;
   logic           sdin;
   logic           dc;
   logic           frame_begin;
   logic           busy;

   modport master (input  enable, oled_data,
                   output X, Y, cs_n, sclk, sdin, dc, frame_begin, busy);

   modport slave  (output enable, oled_data,
                   input  X, Y, cs_n, sclk, sdin, dc, frame_begin, busy);

endinterface

// File: rtl/spi_shift16.sv
// 16-bit MSB-first SPI serialiser: CLK_DIV cycles per SCLK half-period, done on bit 0's last high cycle.
module spi_shift16
   import oled_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
)(
   input  logic    clk,
   input  logic    reset,
   input  logic    i_load,
   input  rgb565_t i_data,
   input  logic    i_start,
   output logic    o_sclk,
   output logic    o_sdin,
   output logic    o_done_c
);

   localparam int unsigned     PH_W    = $clog2(CLK_DIV) + 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

   logic [PIX_W-1:0] r_shift;
   logic [PH_W-1:0]  r_phase;
   logic [3:0]       r_bit;
   logic             r_active;
   logic             r_sclk;
   logic             r_sdin;
   logic [PIX_W-1:0] w_data;
   logic             w_phase_end;

   assign w_data      = i_data;
   assign w_phase_end = r_active && (r_phase == PH_LAST);
   assign o_done_c    = w_phase_end && r_sclk && (r_bit == 4'd0);
   assign o_sclk      = r_sclk;
   assign o_sdin      = r_sdin;

   // The first MSB comes straight from the load data so it is valid in the first low cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shift  <= '0;
         r_phase  <= '0;
         r_bit    <= 4'd0;
         r_active <= 1'b0;
         r_sclk   <= 1'b1;
         r_sdin   <= 1'b0;
      end else begin
         if (i_load) begin
            r_shift <= w_data;
         end
         if (i_start) begin
            r_active <= 1'b1;
            r_phase  <= '0;
            r_bit    <= 4'd15;
            r_sclk   <= 1'b0;
            r_sdin   <= i_load ? w_data[PIX_W-1] : r_shift[PIX_W-1];
         end else if (w_phase_end) begin
            r_phase <= '0;
            if (!r_sclk) begin
               r_sclk <= 1'b1;
            end else if (r_bit == 4'd0) begin
               r_active <= 1'b0;
            end else begin
               r_shift <= {r_shift[PIX_W-2:0], 1'b0};
               r_bit   <= r_bit - 4'd1;
               r_sclk  <= 1'b0;
               r_sdin  <= r_shift[PIX_W-2];
            end
         end else if (r_active) begin
            r_phase <= r_phase + 1'b1;
         end
      end
   end

endmodule

// File: rtl/oled_pixel_streamer.sv
// OLED scan-out engine: walks X/Y over the panel and streams each rendered pixel over SPI.
module oled_pixel_streamer
   import oled_pkg::*;
#(
   parameter int unsigned WIDTH   = OLED_WIDTH,
   parameter int unsigned HEIGHT  = OLED_HEIGHT,
   parameter int unsigned CLK_DIV = 4
)(
   input  logic                  clk,
   input  logic                  reset,
   oled_pixel_streamer_if.master bus
);

   localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

   state_t         r_state;
   logic [X_W-1:0] r_x;
   logic [Y_W-1:0] r_y;
   logic           r_cs_n;
   logic           r_dc;
   logic           r_frame_begin;
   logic           r_busy;

   logic           w_load;
   logic           w_done;
   logic           w_sclk;
   logic           w_sdin;
   logic [X_W-1:0] w_x_next;
   logic [Y_W-1:0] w_y_next;

   assign w_load = (r_state == LOAD);

   // Next scan position, wrapping at row and frame end.
   always_comb begin
      w_x_next = X_W'(r_x + 1'b1);
      w_y_next = r_y;
      if (r_x == X_LAST) begin
         w_x_next = '0;
         w_y_next = (r_y == Y_LAST) ? '0 : Y_W'(r_y + 1'b1);
      end
   end

   spi_shift16 #(.CLK_DIV(CLK_DIV)) u_spi (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_load),
      .i_data   (bus.oled_data),
      .i_start  (w_load),
      .o_sclk   (w_sclk),
      .o_sdin   (w_sdin),
      .o_done_c (w_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_x           <= '0;
         r_y           <= '0;
         r_cs_n        <= 1'b1;
         r_dc          <= 1'b0;
         r_frame_begin <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_frame_begin <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cs_n <= 1'b1;
               if (bus.enable) begin
                  r_state       <= LOAD;
                  r_cs_n        <= 1'b0;
                  r_dc          <= 1'b1;
                  r_busy        <= 1'b1;
                  r_frame_begin <= (r_x == '0) && (r_y == '0);
               end
            end
            LOAD: r_state <= SHIFT;
            SHIFT: begin
               // Coordinates move only at pixel end so the renderer settles for a whole pixel.
               if (w_done) begin
                  r_x <= w_x_next;
                  r_y <= w_y_next;
                  if (bus.enable) begin
                     r_state       <= LOAD;
                     r_frame_begin <= (w_x_next == '0) && (w_y_next == '0);
                  end else begin
                     r_state <= IDLE;
                     r_cs_n  <= 1'b1;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.X           = r_x;
   assign bus.Y           = r_y;
   assign bus.cs_n        = r_cs_n;
   assign bus.sclk        = w_sclk;
   assign bus.sdin        = w_sdin;
   assign bus.dc          = r_dc;
   assign bus.frame_begin = r_frame_begin;
   assign bus.busy        = r_busy;

endmodule
